serial_addsub_unit: RTL

//   Bit-serial two's-complement adder/subtractor for the calculator datapath.

---
 rtl/serial_addsub_if.sv | 27 ++
 rtl/serial_addsub_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_addsub_if.sv
// Start/Ready/Done handshake plus operand and result/flag bus of the bit-serial
// adder/subtractor; the unit takes the slave side, its requester the master side.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Binvert;
  logic             Ready;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             Carry_out;
  logic             Overflow;
  logic             Zero;

  modport master (
    output Start, A, B, Binvert,
    input  Ready, Busy, Done, Result, Carry_out, Overflow, Zero
  );

  modport slave (
    input  Start, A, B, Binvert,
    output Ready, Busy, Done, Result, Carry_out, Overflow, Zero
  );
endinterface

// File: rtl/serial_addsub_unit.sv
// Bit-serial two's-complement adder/subtractor: one operand bit per clock, LSB first,
// with result and Carry_out/Overflow/Zero flags held until the next op completes.
module serial_addsub_unit #(
  parameter int WIDTH = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  serial_addsub_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh;

  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;

  logic [1:0]       w_fa;
  logic             w_a;
  logic             w_b;
  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_sh_nxt;

  // {carry, sum} of a single-bit full adder
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  assign w_a      = r_opa[0];
  assign w_b      = r_opb[0];
  assign w_fa     = full_add(w_a, w_b, r_c);
  assign w_sum    = w_fa[0];
  assign w_cout   = w_fa[1];
  assign w_sh_nxt = {w_sum, r_sh[WIDTH-1:1]};

  // FSM state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags registered from the next state so they track the state register exactly
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Operand capture and serial shift; subtract folds into ~B with carry-in 1
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_opa <= {WIDTH{1'b0}};
      r_opb <= {WIDTH{1'b0}};
      r_c   <= 1'b0;
      r_cnt <= {CW{1'b0}};
      r_sh  <= {WIDTH{1'b0}};
    end else if (w_accept) begin
      r_opa <= bus.A;
      r_opb <= bus.B ^ {WIDTH{bus.Binvert}};
      r_c   <= bus.Binvert;
      r_cnt <= {CW{1'b0}};
      r_sh  <= {WIDTH{1'b0}};
    end else if (r_state == S_RUN) begin
      r_opa <= {1'b0, r_opa[WIDTH-1:1]};
      r_opb <= {1'b0, r_opb[WIDTH-1:1]};
      r_c   <= w_cout;
      r_cnt <= r_cnt + CW'(1);
      r_sh  <= w_sh_nxt;
    end
  end

  // Result and flags update only on the last bit, otherwise hold the previous op
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_result <= {WIDTH{1'b0}};
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_last) begin
      r_result <= w_sh_nxt;
      r_carry  <= w_cout;
      r_ovf    <= (w_a & w_b & ~w_sum) | (~w_a & ~w_b & w_sum);
      r_zero   <= (w_sh_nxt == {WIDTH{1'b0}});
    end
  end

  assign bus.Ready     = r_ready;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.Result    = r_result;
  assign bus.Carry_out = r_carry;
  assign bus.Overflow  = r_ovf;
  assign bus.Zero      = r_zero;

endmodule
